// File: rtl/cs_product_resolver.sv
// Carry-save product resolver: two-stage valid/ready pipeline that resolves sum/carry,
// normalises to a 1.7 BF16 significand and reports the exponent adjustment.
// Optional round-to-nearest-even is enabled by defining CS_RESOLVER_RNE_EN (default: truncate).
module cs_product_resolver #(
  parameter int IN_W   = 17,
  parameter int MANT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   mults,
  input  logic [IN_W-1:0]   multc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_out,
  output logic [1:0]        exp_inc,
  output logic              zero,
  output logic              denorm,
  output logic              inexact
);

  localparam int P_W = IN_W - 1;

  logic              readyEn_q;
  logic              s1Valid_q, s1Valid_d;
  logic [P_W-1:0]    prod_q;
  logic              s2Valid_q, s2Valid_d;
  logic [MANT_W-1:0] mant_q;
  logic [1:0]        expInc_q;
  logic              zero_q, denorm_q, inexact_q;

  logic              s2Load, s1Advance, s1Accept;
  logic [IN_W-1:0]   csSum;
  logic              unusedBits;

  // The carry vector carries weight x2; bit 16 of the sum and of multc fall off the product.
  assign csSum      = mults + {multc[IN_W-2:0], 1'b0};
  assign unusedBits = ^{csSum[IN_W-1], multc[IN_W-1]};

  assign s2Load    = ~s2Valid_q | out_ready;
  assign s1Advance = s1Valid_q & s2Load;
  assign in_ready  = readyEn_q & (~s1Valid_q | s1Advance);
  assign s1Accept  = in_valid & in_ready;

  always_comb begin
    s1Valid_d = s1Valid_q;
    if (s1Accept)       s1Valid_d = 1'b1;
    else if (s1Advance) s1Valid_d = 1'b0;
    s2Valid_d = s2Valid_q;
    if (s2Load)         s2Valid_d = s1Valid_q;
  end

  logic [MANT_W-1:0] mDec, mantDec;
  logic [1:0]        incDec, expDec;
  logic              gDec, sDec, zeroDec, denormDec, roundUp;

  always_comb begin
    mDec      = '0;
    gDec      = 1'b0;
    sDec      = 1'b0;
    incDec    = 2'd0;
    zeroDec   = 1'b0;
    denormDec = 1'b0;
    if (prod_q == '0) begin
      zeroDec = 1'b1;
    end else if (prod_q[15]) begin
      mDec   = prod_q[15:8];
      gDec   = prod_q[7];
      sDec   = |prod_q[6:0];
      incDec = 2'd1;
    end else begin
      // Unnormalised products keep the same window; no extra left shift is attempted.
      mDec      = prod_q[14:7];
      gDec      = prod_q[6];
      sDec      = |prod_q[5:0];
      denormDec = ~prod_q[14];
    end
`ifdef CS_RESOLVER_RNE_EN
    roundUp = gDec & (sDec | mDec[0]);
`else
    roundUp = 1'b0;
`endif
    mantDec = mDec;
    expDec  = incDec;
    if (roundUp) begin
      if (mDec == 8'hFF) begin
        mantDec = 8'h80;
        expDec  = incDec + 2'd1;
      end else begin
        mantDec = mDec + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readyEn_q <= 1'b0;
      s1Valid_q <= 1'b0;
      prod_q    <= '0;
      s2Valid_q <= 1'b0;
      mant_q    <= '0;
      expInc_q  <= 2'd0;
      zero_q    <= 1'b0;
      denorm_q  <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      readyEn_q <= 1'b1;
      s1Valid_q <= s1Valid_d;
      s2Valid_q <= s2Valid_d;
      if (s1Accept) prod_q <= csSum[P_W-1:0];
      // Result registers only move when a real stage-1 entry advances, keeping stalls stable.
      if (s1Advance) begin
        mant_q    <= mantDec;
        expInc_q  <= expDec;
        zero_q    <= zeroDec;
        denorm_q  <= denormDec;
        inexact_q <= gDec | sDec;
      end
    end
  end

  assign out_valid = s2Valid_q;
  assign mant_out  = mant_q;
  assign exp_inc   = expInc_q;
  assign zero      = zero_q;
  assign denorm    = denorm_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_cs_product_resolver.sv
// Directed self-checking bench for cs_product_resolver; expectations follow CS_RESOLVER_RNE_EN.
module tb_cs_product_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] mults;
  logic [16:0] multc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  mant_out;
  logic [1:0]  exp_inc;
  logic        zero;
  logic        denorm;
  logic        inexact;

  int vecCount = 0;
  int errCount = 0;

  logic [16:0] streamP   [8] = '{17'h04000, 17'h08000, 17'h04100, 17'h0C300,
                                 17'h05500, 17'h0FF00, 17'h06000, 17'h09100};
  logic [7:0]  streamM   [8] = '{8'h80, 8'h80, 8'h82, 8'hC3, 8'hAA, 8'hFF, 8'hC0, 8'h91};
  logic [1:0]  streamE   [8] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};

  cs_product_resolver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mults     (mults),
    .multc     (multc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mant_out  (mant_out),
    .exp_inc   (exp_inc),
    .zero      (zero),
    .denorm    (denorm),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one vector into an empty pipeline with out_ready high, then checks latency and result.
  task automatic applyStimulus(input string tag, input logic [16:0] s, input logic [16:0] c,
                               input logic [7:0] em, input logic [1:0] ei, input logic ez,
                               input logic ed, input logic ex);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mults     = s;
    multc     = c;
    #1 checkOutput({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mults    = 17'h1FFFF;
    multc    = 17'h1FFFF;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    checkOutput({tag, "_latency"}, lat, 2);
    checkOutput({tag, "_mant"}, mant_out, em);
    checkOutput({tag, "_exp_inc"}, exp_inc, ei);
    checkOutput({tag, "_zero"}, zero, ez);
    checkOutput({tag, "_denorm"}, denorm, ed);
    checkOutput({tag, "_inexact"}, inexact, ex);
    @(posedge clk);
    #1 checkOutput({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    int sent, recv, staleSeen;
    logic sawFull, prevStall;
    logic [7:0] heldM;
    logic [1:0] heldE;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mults = '0; multc = '0;
    #12;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_mant", mant_out, 0);
    checkOutput("reset_exp_inc", exp_inc, 0);
    checkOutput("reset_flags", {zero, denorm, inexact}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("ready_after_release", in_ready, 1);

    applyStimulus("t1_p4000", 17'h02000, 17'h01000, 8'h80, 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus("t2_ffxff", 17'h0FE01, 17'h00000, 8'hFE, 2'd1, 1'b0, 1'b0, 1'b1);
    applyStimulus("t3_tie_even", 17'h04040, 17'h00000, 8'h80, 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("t_zero", 17'h00000, 17'h00000, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("t_carry_zero", 17'h10000, 17'h18000, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus("t_wrap_denorm", 17'h1FFFF, 17'h00001, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus("t_denorm", 17'h02001, 17'h00000, 8'h40, 2'd0, 1'b0, 1'b1, 1'b1);
`ifdef CS_RESOLVER_RNE_EN
    applyStimulus("t3_tie_odd", 17'h040C0, 17'h00000, 8'h82, 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("t4_ovf", 17'h07FC0, 17'h00000, 8'h80, 2'd1, 1'b0, 1'b0, 1'b1);
    applyStimulus("t_round_hi", 17'h08181, 17'h00000, 8'h82, 2'd1, 1'b0, 1'b0, 1'b1);
    applyStimulus("t_inc2", 17'h0FF80, 17'h00000, 8'h80, 2'd2, 1'b0, 1'b0, 1'b1);
`else
    applyStimulus("t3_tie_odd", 17'h040C0, 17'h00000, 8'h81, 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("t4_ovf", 17'h07FC0, 17'h00000, 8'hFF, 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("t_round_hi", 17'h08181, 17'h00000, 8'h81, 2'd1, 1'b0, 1'b0, 1'b1);
    applyStimulus("t_inc2", 17'h0FF80, 17'h00000, 8'hFF, 2'd1, 1'b0, 1'b0, 1'b1);
`endif

    // Back-to-back stream with a four-cycle downstream stall.
    sent = 0; recv = 0; sawFull = 1'b0; prevStall = 1'b0; heldM = '0; heldE = '0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 8);
      mults     = (sent < 8) ? streamP[sent] : 17'h1FFFF;
      multc     = 17'h00000;
      #1;
      if (!in_ready) sawFull = 1'b1;
      if (out_valid) begin
        if (prevStall) begin
          checkOutput("stream_hold_mant", mant_out, heldM);
          checkOutput("stream_hold_exp", exp_inc, heldE);
        end
        if (out_ready) begin
          checkOutput($sformatf("stream_mant_%0d", recv), mant_out, streamM[recv]);
          checkOutput($sformatf("stream_exp_%0d", recv), exp_inc, streamE[recv]);
          recv++;
          prevStall = 1'b0;
        end else begin
          heldM = mant_out;
          heldE = exp_inc;
          prevStall = 1'b1;
        end
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk) in_valid = 1'b0;
    checkOutput("stream_sent", sent, 8);
    checkOutput("stream_received", recv, 8);
    checkOutput("stream_backpressure", sawFull, 1);
    #1 checkOutput("stream_no_extra", out_valid, 0);

    // Fill both stages, then reset asynchronously mid-cycle.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; mults = 17'h04000; multc = '0;
    @(negedge clk) mults = 17'h08000;
    @(negedge clk) in_valid = 1'b0;
    #1;
    checkOutput("full_out_valid", out_valid, 1);
    checkOutput("full_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", out_valid, 0);
    checkOutput("async_reset_mant", mant_out, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    staleSeen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) staleSeen++;
    end
    checkOutput("no_stale_after_reset", staleSeen, 0);
    checkOutput("ready_after_reset2", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
